// File: rtl/adpcm_pkg.sv
// Shared ADPCM datapath widths and types, reused by the ADDA, ANTILOG and
// scale-factor adaptation blocks.
package adpcm_pkg;

    localparam int DQL_W   = 12;
    localparam int Y_W     = 13;
    localparam int Y_SHIFT = 2;

    typedef logic [DQL_W-1:0] dql_t;
    typedef logic [Y_W-1:0]   y_t;

    // Modulo-2^DQL_W add of DQLN and the zero-extended, right-shifted scale factor.
    function automatic dql_t log_add(input dql_t dqln, input y_t y);
        dql_t y_ext_s;
        y_ext_s = dql_t'(y >> Y_SHIFT);
        return dqln + y_ext_s;
    endfunction

endpackage

// File: rtl/adda_if.sv
// Sample/result bundle between the quantizer datapath and the ADDA stage.
interface adda_if
    import adpcm_pkg::*;
#(
    parameter int DQL_W = adpcm_pkg::DQL_W,
    parameter int Y_W   = adpcm_pkg::Y_W
);
    logic [DQL_W-1:0] DQLN;
    logic [Y_W-1:0]   Y;
    logic             in_valid;
    logic [DQL_W-1:0] DQL;
    logic             out_valid;

    modport master (
        output DQLN,
        output Y,
        output in_valid,
        input  DQL,
        input  out_valid
    );

    modport slave (
        input  DQLN,
        input  Y,
        input  in_valid,
        output DQL,
        output out_valid
    );
endinterface

// File: rtl/adda_core.sv
// Purely combinational modulo adder: DQLN + (Y >> Y_SHIFT), carry discarded.
module adda_core
    import adpcm_pkg::*;
#(
    parameter int DQL_W   = adpcm_pkg::DQL_W,
    parameter int Y_W     = adpcm_pkg::Y_W,
    parameter int Y_SHIFT = adpcm_pkg::Y_SHIFT
) (
    input  logic [DQL_W-1:0] dqln,
    input  logic [Y_W-1:0]   y,
    output logic [DQL_W-1:0] sum
);

    logic [DQL_W-1:0] y_ext_s;
    logic [DQL_W-1:0] sum_s;

    // The shifted scale factor is unsigned, so it is zero-extended, never sign-extended.
    always_comb begin
        y_ext_s = {DQL_W{1'b0}};
        sum_s   = {DQL_W{1'b0}};
        y_ext_s = DQL_W'(y >> Y_SHIFT);
        sum_s   = dqln + y_ext_s;
    end

    assign sum = sum_s;

endmodule

// File: rtl/adda.sv
// ADDA stage: log-domain scale-factor add followed by one output/valid register.
module adda
    import adpcm_pkg::*;
#(
    parameter int DQL_W   = adpcm_pkg::DQL_W,
    parameter int Y_W     = adpcm_pkg::Y_W,
    parameter int Y_SHIFT = adpcm_pkg::Y_SHIFT
) (
    input  logic  clk,
    input  logic  reset_n,
    adda_if.slave bus
);

    logic [DQL_W-1:0] sum_s;
    logic [DQL_W-1:0] dql_r;
    logic             out_valid_r;

    adda_core #(
        .DQL_W   (DQL_W),
        .Y_W     (Y_W),
        .Y_SHIFT (Y_SHIFT)
    ) u_core (
        .dqln (bus.DQLN),
        .y    (bus.Y),
        .sum  (sum_s)
    );

    // Capture the sum on a valid sample; DQL holds between samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dql_r       <= {DQL_W{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            if (bus.in_valid) begin
                dql_r <= sum_s;
            end else begin
                dql_r <= dql_r;
            end
            out_valid_r <= bus.in_valid;
        end
    end

    assign bus.DQL       = dql_r;
    assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_adda.sv
// Self-checking bench for adda: directed vector table, reset corner cases and
// a randomized run against an arithmetic reference model.
module tb_adda;
    import adpcm_pkg::*;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_bad;

    adda_if #(.DQL_W(12), .Y_W(13)) bus ();

    adda #(.DQL_W(12), .Y_W(13), .Y_SHIFT(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] dqln;
        logic [12:0] y;
        logic [11:0] exp_dql;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [11:0] d, input logic [12:0] y, input logic v);
        @(negedge clk);
        bus.DQLN     = d;
        bus.Y        = y;
        bus.in_valid = v;
        @(posedge clk);
        #1;
    endtask

    int exp_dql;
    int exp_valid;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        bus.DQLN     = 12'h000;
        bus.Y        = 13'h0000;
        bus.in_valid = 1'b0;
        reset_n      = 1'b0;

        // Reset held: random valid inputs must not reach the outputs.
        for (int i = 0; i < 5; i++) begin
            drive(12'($urandom), 13'($urandom), 1'b1);
            check("reset_hold_dql", int'(bus.DQL), 0);
            check("reset_hold_valid", int'(bus.out_valid), 0);
        end
        @(negedge clk);
        reset_n = 1'b1;

        vecs.push_back('{12'h123, 13'h0A00, 12'h3A3, "basic_add"});
        vecs.push_back('{12'h000, 13'h0003, 12'h000, "shift_drop"});
        vecs.push_back('{12'h000, 13'h0004, 12'h001, "shift_one"});
        vecs.push_back('{12'h800, 13'h1FFF, 12'hFFF, "max_no_wrap"});
        vecs.push_back('{12'hFFF, 13'h0004, 12'h000, "wrap_zero"});
        vecs.push_back('{12'hFFF, 13'h1FFF, 12'h7FE, "wrap_max"});
        vecs.push_back('{12'h7FF, 13'h0004, 12'h800, "sign_cross"});
        vecs.push_back('{12'h000, 13'h1FFC, 12'h7FF, "y_top_zero_ext"});

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].dqln, vecs[i].y, 1'b1);
            check(vecs[i].name, int'(bus.DQL), int'(vecs[i].exp_dql));
            check({vecs[i].name, "_valid"}, int'(bus.out_valid), 1);
        end

        // Hold: result 0x3A3 must persist while in_valid is low.
        drive(12'h123, 13'h0A00, 1'b1);
        check("hold_load", int'(bus.DQL), 'h3A3);
        drive(12'h555, 13'h1234, 1'b0);
        check("hold_dql", int'(bus.DQL), 'h3A3);
        check("hold_valid", int'(bus.out_valid), 0);
        drive(12'hABC, 13'h0FFF, 1'b0);
        check("hold_dql2", int'(bus.DQL), 'h3A3);

        // Asynchronous reset mid-cycle clears outputs without a clock edge.
        drive(12'h111, 13'h0100, 1'b1);
        check("pre_async_dql", int'(bus.DQL), 'h151);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_dql", int'(bus.DQL), 0);
        check("async_rst_valid", int'(bus.out_valid), 0);
        @(negedge clk);
        bus.DQLN = 12'h001;
        bus.Y    = 13'h0008;
        bus.in_valid = 1'b1;
        reset_n  = 1'b1;
        @(posedge clk);
        #1;
        check("first_after_release", int'(bus.DQL), 'h003);
        check("first_after_release_valid", int'(bus.out_valid), 1);

        // Random regression against an arithmetic model.
        exp_dql = 'h003;
        for (int i = 0; i < 1500; i++) begin
            logic [11:0] d;
            logic [12:0] y;
            logic        v;
            d = 12'($urandom);
            y = 13'($urandom);
            v = 1'($urandom_range(0, 3) != 0);
            if (v) exp_dql = (int'(d) + int'(y) / 4) % 4096;
            exp_valid = v ? 1 : 0;
            drive(d, y, v);
            check("rand_dql", int'(bus.DQL), exp_dql);
            check("rand_valid", int'(bus.out_valid), exp_valid);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
